// File: rtl/md_pkg.sv
// Shared MD issue definitions: opcodes, FSM state encoding, default latencies
// and opcode classification helpers.
package md_pkg;

  localparam logic [3:0] MD_NONE   = 4'd0;
  localparam logic [3:0] MD_MULT   = 4'd1;
  localparam logic [3:0] MD_MULTU  = 4'd2;
  localparam logic [3:0] MD_DIV    = 4'd3;
  localparam logic [3:0] MD_DIVU   = 4'd4;
  localparam logic [3:0] MD_MTLO   = 4'd5;
  localparam logic [3:0] MD_MTHI   = 4'd6;
  localparam logic [3:0] MD_MFHILO = 4'd7;
  localparam logic [3:0] MD_SWAP   = 4'd8;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } md_state_e;

  function automatic logic md_is_launch(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_use(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_SWAP);
  endfunction

  // Reads of HI/LO need nothing from the E-stage unit, so they travel as a bubble.
  function automatic logic [3:0] md_issue_op(input logic [3:0] op);
    return (md_is_use(op) && (op != MD_MFHILO)) ? op : MD_NONE;
  endfunction

endpackage

// File: rtl/md_busy_chk.sv
// Sticky comparator between the controller's own BUSY state and the busy flag
// reported back by the MD unit.
module md_busy_chk (
  input  logic clk,
  input  logic reset,
  input  logic busy_exp,
  input  logic busy_act,
  output logic mismatch
);

  logic mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q | (busy_exp != busy_act);
  end

  always_ff @(posedge clk) begin
    if (reset) mismatch_q <= 1'b0;
    else       mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// MD issue/hazard controller: issues MD ops into E and stalls F/D while the unit is occupied.
// Optional busy-mirror checker compiled in with macro MD_BUSY_CHECK_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] D_MDOp,
  input  logic       D_StallIn,
  input  logic       E_Flush,
  input  logic       E_Busy,
  output logic [3:0] E_MDControl,
  output logic       Stall,
  output logic       Mismatch
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] e_md_ctrl_q, e_md_ctrl_d;
  logic       stall;

  always_comb begin
    stall       = md_is_use(D_MDOp) && (state_q != ST_IDLE);
    e_md_ctrl_d = (E_Flush || stall || D_StallIn) ? MD_NONE : md_issue_op(D_MDOp);
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (md_is_launch(e_md_ctrl_d)) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
        cnt_d   = (e_md_ctrl_q <= MD_MULTU) ? MULT_LOAD : DIV_LOAD;
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // A zero-length parameter lands here with cnt 0; treat it as done too.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = md_is_launch(e_md_ctrl_d) ? ST_LAUNCH : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      e_md_ctrl_q <= MD_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      e_md_ctrl_q <= e_md_ctrl_d;
    end
  end

  assign E_MDControl = e_md_ctrl_q;
  assign Stall       = stall;

`ifdef MD_BUSY_CHECK_EN
  md_busy_chk u_busy_chk (
    .clk      (clk),
    .reset    (reset),
    .busy_exp (state_q == ST_BUSY),
    .busy_act (E_Busy),
    .mismatch (Mismatch)
  );
`else
  logic unused_e_busy;
  assign unused_e_busy = E_Busy;
  assign Mismatch      = 1'b0;
`endif

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles after a mult/multu launch.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles after a div/divu launch.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port D_MDOp  input  4  D-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 mfhi/mflo, 8 swap; 9-15 treated as 0.
REQ-006 SHALL have port D_StallIn  input  1  stall request from other hazard logic.
REQ-007 SHALL have port E_Flush  input  1  bubble request into E stage.
REQ-008 SHALL have port E_Busy  input  1  busy flag returned by the MD unit.
REQ-009 SHALL have port E_MDControl  output  4  registered MD command driven to the E-stage MD unit.
REQ-010 SHALL have port Stall  output  1  MD-hazard stall for F/D stages.
REQ-011 SHALL have port Mismatch  output  1  sticky busy-mirror error flag.

Function
REQ-012 SHALL classify ops 1-4 as launch ops and ops 1-8 as MD-using ops.
REQ-013 SHALL keep a down-counter cnt, 4 bits, tracking remaining MD busy cycles.
REQ-014 SHALL implement FSM IDLE, LAUNCH, BUSY.
REQ-015 SHALL be in LAUNCH exactly in cycles where E_MDControl holds a launch op.
REQ-016 SHALL, on leaving LAUNCH, load cnt with MULT_CYCLES for ops 1-2, DIV_CYCLES for ops 3-4, and enter BUSY.
REQ-017 SHALL decrement cnt once per cycle in BUSY, and go to IDLE when cnt reaches 0, unless a new launch op is registered that edge (then LAUNCH).
REQ-018 SHALL assert Stall combinationally when D_MDOp is MD-using and state is LAUNCH or BUSY.
REQ-019 SHALL register E_MDControl <= 0 when E_Flush, Stall or D_StallIn is high, else <= D_MDOp (op 7 and 9-15 registered as 0).
REQ-020 SHALL give E_Flush priority over every other E_MDControl load source.
REQ-021 SHALL let an op already in LAUNCH/BUSY finish its count regardless of E_Flush or D_StallIn.
REQ-022 SHALL allow ops 5, 6, 8 to issue in IDLE without changing state or cnt.
REQ-023 SHALL allow back-to-back issue: a launch op in D while cnt=1 in BUSY still stalls; it issues the cycle state is IDLE.
REQ-024 SHALL never stall a D_MDOp of 0.

Reset
REQ-025 SHALL on reset set state IDLE, cnt 0, E_MDControl 0, Mismatch 0; Stall is 0 in the reset-following cycle.
REQ-026 SHALL abandon any in-flight count on reset mid-operation.

Configuration
REQ-027 SHALL compile the checker in when macro MD_BUSY_CHECK_EN is defined: each cycle compare E_Busy with (state==BUSY), set Mismatch on inequality, hold it until reset.
REQ-028 SHALL, without MD_BUSY_CHECK_EN, tie Mismatch to 0 and leave E_Busy unused.

Structure
REQ-029 SHALL place opcode constants (MD_NONE..MD_SWAP), FSM state encoding and default cycle counts in shared package md_pkg.
REQ-030 SHALL implement the checker as sub-module md_busy_chk, instantiated only under MD_BUSY_CHECK_EN.

Verification
REQ-031 SHALL test mult: D_MDOp=1 at T0 -> E_MDControl=1 at T1, cnt=5 at T2, Stall high for a D mfhi across T1..T6, low at T7.
REQ-032 SHALL test divu then mflo: D_MDOp=4 then 7 -> Stall high 11 cycles, E_MDControl=0 throughout, mflo issues after cnt=0.
REQ-033 SHALL test flush priority: E_Flush=1 with D_MDOp=3 in IDLE -> E_MDControl=0, state stays IDLE, Stall 0.
REQ-034 SHALL test reset mid-op: reset at cnt=3 after div -> next cycle state IDLE, cnt 0, Stall 0 with D_MDOp=1.
REQ-035 SHALL test mtlo/mthi/swap: ops 5, 6, 8 in consecutive IDLE cycles -> each registered unchanged, no Stall.
REQ-036 SHALL test the checker with MD_BUSY_CHECK_EN: hold E_Busy=0 during BUSY -> Mismatch=1 next cycle, stays 1 until reset.
